// File: rtl/scr1_imem_timeout.sv
// scr1_imem_timeout: IMEM port watchdog.
// Passes the address and data phases through with no added latency. If the
// downstream target leaves a data phase unanswered for SCR1_TIMEOUT cycles,
// one RDY_ER is returned upstream and the late response is swallowed later,
// so a hung target cannot lock up instruction fetch.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | address phase, req/ack passed straight through
// WAIT  | data phase outstanding, resp/rdata forwarded, timer running
// ERR   | timer expired, RDY_ER returned upstream for exactly one cycle
// DRAIN | downstream still owes a response, upstream stalled until it lands

package scr1_imem_timeout_pkg;

   localparam int SCR1_IMEM_AWIDTH = 32;
   localparam int SCR1_IMEM_DWIDTH = 32;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

endpackage : scr1_imem_timeout_pkg

module scr1_imem_timeout
   import scr1_imem_timeout_pkg::*;
#(
   parameter int unsigned SCR1_TIMEOUT = 255
)(
   input  logic                          clk,
   input  logic                          rst_n,

   output logic                          up_req_ack,
   input  logic                          up_req,
   input  type_scr1_mem_cmd_e            up_cmd,
   input  logic [SCR1_IMEM_AWIDTH-1:0]   up_addr,
   output logic [SCR1_IMEM_DWIDTH-1:0]   up_rdata,
   output type_scr1_mem_resp_e           up_resp,

   input  logic                          dn_req_ack,
   output logic                          dn_req,
   output type_scr1_mem_cmd_e            dn_cmd,
   output logic [SCR1_IMEM_AWIDTH-1:0]   dn_addr,
   input  logic [SCR1_IMEM_DWIDTH-1:0]   dn_rdata,
   input  type_scr1_mem_resp_e           dn_resp,

   output logic                          timeout_evt,
   output logic                          timeout_flag
);

   localparam int CNT_W = $clog2(SCR1_TIMEOUT + 1);
   // Timer counts down the remaining data-phase cycles; zero is the last
   // cycle on which a response is still forwarded.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SCR1_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WAIT  = 2'b01,
      ST_ERR   = 2'b10,
      ST_DRAIN = 2'b11
   } state_e;

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             flag_q;
   logic             handshake;
   logic             dn_resp_vld;

   assign handshake   = up_req & dn_req_ack;
   assign dn_resp_vld = (dn_resp != SCR1_MEM_RESP_NOTRDY);

   assign dn_cmd  = up_cmd;
   assign dn_addr = up_addr;

   // State, timer and sticky timeout flag; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         flag_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (handshake) begin
                  state <= ST_WAIT;
                  cnt   <= CNT_LOAD;
               end
            end
            ST_WAIT: begin
               case (dn_resp)
                  SCR1_MEM_RESP_RDY_OK: begin
                     // A new fetch accepted alongside the response restarts the timer.
                     if (handshake) begin
                        cnt <= CNT_LOAD;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
                  SCR1_MEM_RESP_RDY_ER: begin
                     state <= ST_IDLE;
                  end
                  default: begin
                     if (cnt == '0) begin
                        state <= ST_ERR;
                     end else begin
                        cnt <= cnt - CNT_W'(1);
                     end
                  end
               endcase
            end
            ST_ERR: begin
               flag_q <= 1'b1;
               // A response landing in the error cycle is already paid for.
               state  <= dn_resp_vld ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
               if (dn_resp_vld) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Combinational passthroughs per state; all forced quiet while in reset.
   always_comb begin
      dn_req     = 1'b0;
      up_req_ack = 1'b0;
      up_resp    = SCR1_MEM_RESP_NOTRDY;
      up_rdata   = '0;
      if (rst_n) begin
         case (state)
            ST_IDLE: begin
               dn_req     = up_req;
               up_req_ack = dn_req_ack;
            end
            ST_WAIT: begin
               up_resp  = dn_resp;
               up_rdata = dn_rdata;
               if (dn_resp == SCR1_MEM_RESP_RDY_OK) begin
                  dn_req     = up_req;
                  up_req_ack = dn_req_ack;
               end
            end
            ST_ERR: begin
               up_resp = SCR1_MEM_RESP_RDY_ER;
            end
            default: begin
            end
         endcase
      end
   end

   assign timeout_evt  = rst_n & (state == ST_ERR);
   assign timeout_flag = rst_n & flag_q;

endmodule : scr1_imem_timeout

// File: tb/tb_scr1_imem_timeout.sv
// Bench for scr1_imem_timeout: cycle-by-cycle vector table fed through an
// expectation queue, plus hand sequences for timeout latency and TIMEOUT=1.

module tb_scr1_imem_timeout;
   import scr1_imem_timeout_pkg::*;

   localparam type_scr1_mem_resp_e N = SCR1_MEM_RESP_NOTRDY;
   localparam type_scr1_mem_resp_e O = SCR1_MEM_RESP_RDY_OK;
   localparam type_scr1_mem_resp_e E = SCR1_MEM_RESP_RDY_ER;

   logic                        clk;
   logic                        rst_n;
   logic                        up_req;
   type_scr1_mem_cmd_e          up_cmd;
   logic [SCR1_IMEM_AWIDTH-1:0] up_addr;
   logic                        dn_req_ack;
   logic [SCR1_IMEM_DWIDTH-1:0] dn_rdata;
   type_scr1_mem_resp_e         dn_resp;

   logic                        up_req_ack, dn_req, timeout_evt, timeout_flag;
   type_scr1_mem_cmd_e          dn_cmd;
   logic [SCR1_IMEM_AWIDTH-1:0] dn_addr;
   logic [SCR1_IMEM_DWIDTH-1:0] up_rdata;
   type_scr1_mem_resp_e         up_resp;

   logic                        t1_up_req_ack, t1_dn_req, t1_evt, t1_flag;
   type_scr1_mem_cmd_e          t1_dn_cmd;
   logic [SCR1_IMEM_AWIDTH-1:0] t1_dn_addr;
   logic [SCR1_IMEM_DWIDTH-1:0] t1_up_rdata;
   type_scr1_mem_resp_e         t1_up_resp;

   int checks = 0;
   int errors = 0;

   scr1_imem_timeout #(.SCR1_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .up_req_ack(up_req_ack), .up_req(up_req), .up_cmd(up_cmd), .up_addr(up_addr),
      .up_rdata(up_rdata), .up_resp(up_resp),
      .dn_req_ack(dn_req_ack), .dn_req(dn_req), .dn_cmd(dn_cmd), .dn_addr(dn_addr),
      .dn_rdata(dn_rdata), .dn_resp(dn_resp),
      .timeout_evt(timeout_evt), .timeout_flag(timeout_flag)
   );

   scr1_imem_timeout #(.SCR1_TIMEOUT(1)) dut_t1 (
      .clk(clk), .rst_n(rst_n),
      .up_req_ack(t1_up_req_ack), .up_req(up_req), .up_cmd(up_cmd), .up_addr(up_addr),
      .up_rdata(t1_up_rdata), .up_resp(t1_up_resp),
      .dn_req_ack(dn_req_ack), .dn_req(t1_dn_req), .dn_cmd(t1_dn_cmd), .dn_addr(t1_dn_addr),
      .dn_rdata(dn_rdata), .dn_resp(dn_resp),
      .timeout_evt(t1_evt), .timeout_flag(t1_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1, "bench timeout");
   end

   typedef struct {
      logic                rst_n;
      logic                up_req;
      logic                dn_ack;
      type_scr1_mem_resp_e dn_resp;
      logic [31:0]         dn_rdata;
      logic                e_dn_req;
      logic                e_up_ack;
      type_scr1_mem_resp_e e_resp;
      logic [31:0]         e_rdata;
      logic                e_evt;
      logic                e_flag;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   function automatic vec_t mk(logic r, logic rq, logic ak, type_scr1_mem_resp_e rs,
                               logic [31:0] rd, logic edr, logic eak,
                               type_scr1_mem_resp_e ers, logic [31:0] erd,
                               logic eev, logic efl);
      vec_t v;
      v.rst_n = r;   v.up_req = rq;  v.dn_ack = ak;  v.dn_resp = rs;  v.dn_rdata = rd;
      v.e_dn_req = edr; v.e_up_ack = eak; v.e_resp = ers; v.e_rdata = erd;
      v.e_evt = eev; v.e_flag = efl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step_drive(input vec_t v);
      @(posedge clk);
      #1;
      rst_n      = v.rst_n;
      up_req     = v.up_req;
      dn_req_ack = v.dn_ack;
      dn_resp    = v.dn_resp;
      dn_rdata   = v.dn_rdata;
      up_cmd     = type_scr1_mem_cmd_e'($urandom_range(0, 1));
      up_addr    = $urandom;
      exp_q.push_back(v);
   endtask

   task automatic step_check(input int idx);
      vec_t e;
      @(negedge clk);
      if (exp_q.size() == 0) begin
         chk($sformatf("v%0d_queue_empty", idx), 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk($sformatf("v%0d_dn_req", idx),     32'(dn_req),       32'(e.e_dn_req));
         chk($sformatf("v%0d_up_req_ack", idx), 32'(up_req_ack),   32'(e.e_up_ack));
         chk($sformatf("v%0d_up_resp", idx),    32'(up_resp),      32'(e.e_resp));
         chk($sformatf("v%0d_up_rdata", idx),   up_rdata,          e.e_rdata);
         chk($sformatf("v%0d_evt", idx),        32'(timeout_evt),  32'(e.e_evt));
         chk($sformatf("v%0d_flag", idx),       32'(timeout_flag), 32'(e.e_flag));
         chk($sformatf("v%0d_dn_addr", idx),    dn_addr,           up_addr);
         chk($sformatf("v%0d_dn_cmd", idx),     32'(dn_cmd),       32'(up_cmd));
      end
   endtask

   task automatic drive(input logic rq, input logic ak, input type_scr1_mem_resp_e rs,
                        input logic [31:0] rd);
      @(posedge clk);
      #1;
      up_req = rq; dn_req_ack = ak; dn_resp = rs; dn_rdata = rd;
   endtask

   initial begin
      int k;
      logic found;

      rst_n = 1'b0; up_req = 1'b0; dn_req_ack = 1'b0; dn_resp = N; dn_rdata = '0;
      up_cmd = SCR1_MEM_CMD_RD; up_addr = 32'h0001_0000;

      // reset, inputs active but outputs must stay quiet
      tbl.push_back(mk(0,1,1,O,32'h55, 0,0,N,0,0,0));
      tbl.push_back(mk(0,1,1,O,32'h55, 0,0,N,0,0,0));
      // response on data cycle 2
      tbl.push_back(mk(1,1,1,N,0, 1,1,N,0,0,0));
      tbl.push_back(mk(1,0,0,N,0, 0,0,N,0,0,0));
      tbl.push_back(mk(1,0,0,N,0, 0,0,N,0,0,0));
      tbl.push_back(mk(1,0,0,O,32'hDEADBEEF, 0,0,O,32'hDEADBEEF,0,0));
      tbl.push_back(mk(1,0,0,O,32'h1234, 0,0,N,0,0,0));
      // back-to-back fetch, second response on its cycle 3
      tbl.push_back(mk(1,1,0,N,0, 1,0,N,0,0,0));
      tbl.push_back(mk(1,1,1,N,0, 1,1,N,0,0,0));
      tbl.push_back(mk(1,1,1,O,32'h1111_1111, 1,1,O,32'h1111_1111,0,0));
      tbl.push_back(mk(1,0,0,N,0, 0,0,N,0,0,0));
      tbl.push_back(mk(1,0,0,N,0, 0,0,N,0,0,0));
      tbl.push_back(mk(1,0,0,N,0, 0,0,N,0,0,0));
      tbl.push_back(mk(1,0,0,O,32'h2222_2222, 0,0,O,32'h2222_2222,0,0));
      // timeout, drain, late OK on cycle 7
      tbl.push_back(mk(1,1,1,N,0, 1,1,N,0,0,0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,0,N,0, 0,0,N,0,0,0));
      tbl.push_back(mk(1,1,1,N,32'hABCD, 0,0,E,0,1,0));
      tbl.push_back(mk(1,1,1,N,0, 0,0,N,0,0,1));
      tbl.push_back(mk(1,1,1,N,0, 0,0,N,0,0,1));
      tbl.push_back(mk(1,1,1,O,32'h777, 0,0,N,0,0,1));
      tbl.push_back(mk(1,1,1,N,0, 1,1,N,0,0,1));
      tbl.push_back(mk(1,0,0,O,32'h3333, 0,0,O,32'h3333,0,1));
      // late response in the error cycle itself
      tbl.push_back(mk(1,1,1,N,0, 1,1,N,0,0,1));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,0,N,0, 0,0,N,0,0,1));
      tbl.push_back(mk(1,0,0,O,32'h999, 0,0,E,0,1,1));
      tbl.push_back(mk(1,1,1,N,0, 1,1,N,0,0,1));
      // downstream error on cycle 1, request held but not issued
      tbl.push_back(mk(1,1,1,N,0, 0,0,N,0,0,1));
      tbl.push_back(mk(1,1,1,E,32'h5555, 0,0,E,32'h5555,0,1));
      tbl.push_back(mk(1,0,0,N,0, 0,0,N,0,0,1));
      // reset during drain
      tbl.push_back(mk(1,1,1,N,0, 1,1,N,0,0,1));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,0,N,0, 0,0,N,0,0,1));
      tbl.push_back(mk(1,0,0,N,0, 0,0,E,0,1,1));
      tbl.push_back(mk(1,1,1,N,0, 0,0,N,0,0,1));
      tbl.push_back(mk(0,1,1,O,32'h4444, 0,0,N,0,0,0));
      tbl.push_back(mk(1,0,0,O,32'h4444, 0,0,N,0,0,0));
      tbl.push_back(mk(1,1,1,N,0, 1,1,N,0,0,0));
      tbl.push_back(mk(1,0,0,O,32'h6666, 0,0,O,32'h6666,0,0));

      foreach (tbl[i]) begin
         step_drive(tbl[i]);
         step_check(i);
      end

      // measured timeout latency with a bounded wait; upstream keeps asking
      drive(1, 1, N, 0);
      drive(1, 1, N, 0);
      k = 0; found = 1'b0;
      while (k < 20 && !found) begin
         @(negedge clk);
         if (timeout_evt) begin
            found = 1'b1;
         end else begin
            chk("seq_stall_ack", 32'(up_req_ack), 32'd0);
            @(posedge clk);
            #1;
            k++;
         end
      end
      chk("seq_evt_seen", 32'(found), 32'd1);
      chk("seq_evt_cycle", k, 32'd4);
      chk("seq_err_resp", 32'(up_resp), 32'(E));
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, N, 0);
         @(negedge clk);
         chk("seq_drain_ack", 32'(up_req_ack), 32'd0);
         chk("seq_drain_resp", 32'(up_resp), 32'(N));
         chk("seq_drain_evt", 32'(timeout_evt), 32'd0);
      end
      drive(1, 1, E, 32'hBAD);
      @(negedge clk);
      chk("seq_drain_late_resp", 32'(up_resp), 32'(N));
      drive(1, 1, N, 0);
      @(negedge clk);
      chk("seq_after_drain_ack", 32'(up_req_ack), 32'd1);
      drive(0, 0, O, 32'hCAFE_F00D);
      @(negedge clk);
      chk("seq_after_drain_rdata", up_rdata, 32'hCAFE_F00D);

      // TIMEOUT=1 boundary on the second instance
      @(posedge clk); #1; rst_n = 1'b0; up_req = 0; dn_req_ack = 0; dn_resp = N;
      @(posedge clk); #1; rst_n = 1'b1;
      drive(1, 1, N, 0);
      @(negedge clk);
      chk("t1_hs_ack", 32'(t1_up_req_ack), 32'd1);
      drive(0, 0, N, 0);
      @(negedge clk);
      chk("t1_k0_resp", 32'(t1_up_resp), 32'(N));
      chk("t1_k0_evt", 32'(t1_evt), 32'd0);
      drive(0, 0, O, 32'h77);
      @(negedge clk);
      chk("t1_k1_resp", 32'(t1_up_resp), 32'(E));
      chk("t1_k1_evt", 32'(t1_evt), 32'd1);
      chk("t1_k1_rdata", t1_up_rdata, 32'd0);
      drive(1, 1, N, 0);
      @(negedge clk);
      chk("t1_flag", 32'(t1_flag), 32'd1);
      chk("t1_rehs_ack", 32'(t1_up_req_ack), 32'd1);
      drive(0, 0, O, 32'h8888);
      @(negedge clk);
      chk("t1_k0_ok_resp", 32'(t1_up_resp), 32'(O));
      chk("t1_k0_ok_rdata", t1_up_rdata, 32'h8888);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_scr1_imem_timeout
